forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_BITS, default 3, which sets the register-index width (8 GPRs).
REQ-002 SHALL have port clk, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port id_valid, input, 1 bit: the decode-stage instruction is real.
REQ-005 SHALL have ports id_rs and id_rt, input, REG_BITS each: decode source indices.
REQ-006 SHALL have ports id_rs_used and id_rt_used, input, 1 bit each: the source feeds ALU data1 or data2; id_rt_used=0 when ALU_Src selects the immediate.
REQ-007 SHALL have ports id_wr_en (1), id_wr_reg (REG_BITS) and id_is_load (1), inputs: the decode instruction's destination and its load flag.
REQ-008 SHALL have port flush, input, 1 bit: the decode instruction is wrong-path.
REQ-009 SHALL have port writedata, input, 16 bits: the WB-stage result.
REQ-010 SHALL have ports frwrd_alu1 and frwrd_alu2, output, 2 bits each, registered, with codes 0=regfile/immediate, 1=writedata, 2=alu_out_xm, 3=writedata_prev.
REQ-011 SHALL have port writedata_prev, output, 16 bits, registered: the WB result from one cycle earlier.
REQ-012 SHALL have port stall, output, 1 bit, combinational: hold PC and IF/ID and insert a bubble.

Function
REQ-013 SHALL keep three producer entries, EX, MEM and WB, each holding {valid, wr_en, dest, is_load}.
REQ-014 SHALL shift entries every cycle: WB<=MEM and MEM<=EX; EX<=decode info, or a bubble (valid=0) when stall, flush or !id_valid.
REQ-015 SHALL treat an entry as a producer of register r only if valid & wr_en & dest==r; r0 has no special meaning.
REQ-016 SHALL compute each next select from the current entries, youngest first: EX match gives 2; else MEM match gives 1; else WB match gives 3; else 0.
REQ-017 SHALL force a select to 0 when its *_used input is 0, and force both selects to 0 when the EX entry loaded is a bubble.
REQ-018 SHALL assert stall = id_valid & !flush & EX.valid & EX.wr_en & EX.is_load & ((id_rs_used & id_rs==EX.dest) | (id_rt_used & id_rt==EX.dest)).
REQ-019 SHALL stall exactly one cycle per load-use hazard; in the following cycle the load is in MEM and the select resolves to 1.
REQ-020 SHALL NOT stall for a load in MEM or WB; those are forwarded.
REQ-021 SHALL give flush priority over stall: stall=0, a bubble enters EX, and the next selects are 0.
REQ-022 SHALL load writedata_prev <= writedata when WB.valid & WB.wr_en, and otherwise hold its value.
REQ-023 SHALL apply the same rules to rs and rt independently; when rs==rt both selects carry the same code.
REQ-024 SHALL have selects with latency 1: the selects computed at a decode edge are valid throughout that instruction's EX cycle.

Reset
REQ-025 SHALL on rst clear all entry valid bits, and set frwrd_alu1=frwrd_alu2=0 and writedata_prev=16'h0000.
REQ-026 SHALL hold stall=0 while rst is asserted and in the first cycle after release.
REQ-027 SHALL discard any in-flight hazard when reset asserts mid-stall; no stall after release.

Verification
REQ-028 SHALL cover ADD r3 then ADD r4,r3,r1 back-to-back -> frwrd_alu1=2 in the second instruction's EX cycle, frwrd_alu2=0, stall=0.
REQ-029 SHALL cover LD r2 then ADD r5,r1,r2 -> stall=1 for one cycle, a bubble in EX, then frwrd_alu2=1 and frwrd_alu1=0.
REQ-030 SHALL cover a producer of r6 followed by two independent instructions, then a reader of r6 with WB writedata=16'hBEEF -> frwrd=3 and writedata_prev=16'hBEEF.
REQ-031 SHALL cover EX, MEM and WB entries all writing r1 while decode reads r1 on rs and rt -> both selects=2.
REQ-032 SHALL cover flush=1 coincident with a load-use match -> stall=0, selects 0 next cycle, and no MEM-stage write from the bubble.
REQ-033 SHALL cover an ADDI with ALU_Src (id_rt_used=0) whose rt field matches an EX dest, and rst asserted during a stall -> frwrd_alu2=0; after reset, all outputs are 0 and stall is 0.

Source files
------------

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks the EX/MEM/WB producers and picks ALU operand sources one cycle ahead.
module forward_ctrl #(
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wr_reg,
  input  logic                id_is_load,
  input  logic                flush,
  input  logic [15:0]         writedata,
  output logic [1:0]          frwrd_alu1,
  output logic [1:0]          frwrd_alu2,
  output logic [15:0]         writedata_prev,
  output logic                stall
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WD  = 2'd1;
  localparam logic [1:0] SEL_XM  = 2'd2;
  localparam logic [1:0] SEL_WDP = 2'd3;

  logic                ex_valid_q, ex_wr_en_q, ex_is_load_q;
  logic [REG_BITS-1:0] ex_dest_q;
  logic                mem_valid_q, mem_wr_en_q, mem_is_load_q;
  logic [REG_BITS-1:0] mem_dest_q;
  logic                wb_valid_q, wb_wr_en_q, wb_is_load_q;
  logic [REG_BITS-1:0] wb_dest_q;

  logic                ex_valid_d, ex_wr_en_d, ex_is_load_d;
  logic [REG_BITS-1:0] ex_dest_d;
  logic [15:0]         writedata_prev_q, writedata_prev_d;

  logic       bubble;
  logic [1:0] ex_load_hit;
  logic [1:0] sel_vec [2];

  // One select per ALU operand: index 0 is rs/data1, index 1 is rt/data2.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [REG_BITS-1:0] idx;
    logic                used;
    logic                hit_ex, hit_mem, hit_wb;
    logic [1:0]          sel_d, sel_q;

    assign idx     = (gi == 0) ? id_rs : id_rt;
    assign used    = (gi == 0) ? id_rs_used : id_rt_used;
    assign hit_ex  = ex_valid_q  & ex_wr_en_q  & (ex_dest_q  == idx);
    assign hit_mem = mem_valid_q & mem_wr_en_q & (mem_dest_q == idx);
    assign hit_wb  = wb_valid_q  & wb_wr_en_q  & (wb_dest_q  == idx);
    assign ex_load_hit[gi] = used & hit_ex & ex_is_load_q;

    // Youngest producer wins; a bubble entering EX has no operands to forward.
    always_comb begin
      sel_d = SEL_RF;
      if (used && !bubble) begin
        if (hit_ex)       sel_d = SEL_XM;
        else if (hit_mem) sel_d = SEL_WD;
        else if (hit_wb)  sel_d = SEL_WDP;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sel_q <= SEL_RF;
      else     sel_q <= sel_d;
    end

    assign sel_vec[gi] = sel_q;
  end

  assign stall  = !rst & id_valid & !flush & ex_valid_q & ex_wr_en_q & (|ex_load_hit);
  assign bubble = stall | flush | !id_valid;

  always_comb begin
    ex_valid_d   = !bubble;
    ex_wr_en_d   = id_wr_en;
    ex_dest_d    = id_wr_reg;
    ex_is_load_d = id_is_load;
  end

  always_comb begin
    writedata_prev_d = writedata_prev_q;
    if (wb_valid_q && wb_wr_en_q) writedata_prev_d = writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q       <= 1'b0;
      ex_wr_en_q       <= 1'b0;
      ex_dest_q        <= '0;
      ex_is_load_q     <= 1'b0;
      mem_valid_q      <= 1'b0;
      mem_wr_en_q      <= 1'b0;
      mem_dest_q       <= '0;
      mem_is_load_q    <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_wr_en_q       <= 1'b0;
      wb_dest_q        <= '0;
      wb_is_load_q     <= 1'b0;
      writedata_prev_q <= 16'h0000;
    end else begin
      wb_valid_q       <= mem_valid_q;
      wb_wr_en_q       <= mem_wr_en_q;
      wb_dest_q        <= mem_dest_q;
      wb_is_load_q     <= mem_is_load_q;
      mem_valid_q      <= ex_valid_q;
      mem_wr_en_q      <= ex_wr_en_q;
      mem_dest_q       <= ex_dest_q;
      mem_is_load_q    <= ex_is_load_q;
      ex_valid_q       <= ex_valid_d;
      ex_wr_en_q       <= ex_wr_en_d;
      ex_dest_q        <= ex_dest_d;
      ex_is_load_q     <= ex_is_load_d;
      writedata_prev_q <= writedata_prev_d;
    end
  end

  assign frwrd_alu1     = sel_vec[0];
  assign frwrd_alu2     = sel_vec[1];
  assign writedata_prev = writedata_prev_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: hand-derived expectations per decode cycle.
module tb_forward_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
  logic [2:0]  id_rs, id_rt, id_wr_reg;
  logic [15:0] writedata;
  logic [1:0]  frwrd_alu1, frwrd_alu2;
  logic [15:0] writedata_prev;
  logic        stall;

  typedef struct packed {
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [15:0] wp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  forward_ctrl #(.REG_BITS(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .writedata(writedata), .frwrd_alu1(frwrd_alu1), .frwrd_alu2(frwrd_alu2),
    .writedata_prev(writedata_prev), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic ru, input logic [2:0] rt,
                       input logic tu, input logic we, input logic [2:0] wr, input logic ld,
                       input logic fl, input logic [15:0] wd);
    id_valid = v;  id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld; flush = fl; writedata = wd;
  endtask

  // Called at posedge+1: apply decode, check stall, queue expected post-edge outputs.
  task automatic cyc(input string nm, input logic v, input logic [2:0] rs, input logic ru,
                     input logic [2:0] rt, input logic tu, input logic we, input logic [2:0] wr,
                     input logic ld, input logic fl, input logic [15:0] wd,
                     input logic xs, input logic [1:0] x1, input logic [1:0] x2,
                     input logic [15:0] xp);
    exp_t e;
    drive(v, rs, ru, rt, tu, we, wr, ld, fl, wd);
    #1;
    check({nm, ".stall"}, {15'd0, stall}, {15'd0, xs});
    e.s1 = x1; e.s2 = x2; e.wp = xp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({nm, ".sbq"}, 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check({nm, ".alu1"}, {14'd0, frwrd_alu1}, {14'd0, e.s1});
      check({nm, ".alu2"}, {14'd0, frwrd_alu2}, {14'd0, e.s2});
      check({nm, ".wdprev"}, writedata_prev, e.wp);
    end
    $display("[TB] %s stall=%0d alu1=%0d alu2=%0d wdprev=%h", nm, xs, frwrd_alu1, frwrd_alu2,
             writedata_prev);
  endtask

  task automatic nop(input string nm, input logic [15:0] wd, input logic [15:0] xp);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, wd, 0, 0, 0, xp);
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 3, 1, 3, 1, 1, 3, 1, 0, 16'h1111);
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", {15'd0, stall}, 16'd0);
    check("rst.alu1", {14'd0, frwrd_alu1}, 16'd0);
    check("rst.alu2", {14'd0, frwrd_alu2}, 16'd0);
    check("rst.wdprev", writedata_prev, 16'h0000);
    rst = 1'b0;
    #1;
    check("rel.stall", {15'd0, stall}, 16'd0);
    @(posedge clk);
    #1;
    nop("flush0", 16'h0, 16'h0000);
    nop("flush1", 16'h0, 16'h0000);
    nop("flush2", 16'h0, 16'h0000);

    // ADD r3 then ADD r4,r3,r1 back to back
    cyc("A1", 1, 1, 1, 2, 1, 1, 3, 0, 0, 16'h0, 0, 0, 0, 16'h0000);
    cyc("A2", 1, 3, 1, 1, 1, 1, 4, 0, 0, 16'h0, 0, 2, 0, 16'h0000);
    nop("A3", 16'h0000, 16'h0000);
    nop("A4", 16'h1234, 16'h1234);
    nop("A5", 16'h5555, 16'h5555);
    nop("A6", 16'hAAAA, 16'h5555);

    // LD r2 then ADD r5,r1,r2: one stall, then forward from MEM
    cyc("B1", 1, 1, 1, 0, 0, 1, 2, 1, 0, 16'h0, 0, 0, 0, 16'h5555);
    cyc("B2", 1, 1, 1, 2, 1, 1, 5, 0, 0, 16'h0, 1, 0, 0, 16'h5555);
    cyc("B3", 1, 1, 1, 2, 1, 1, 5, 0, 0, 16'h0, 0, 0, 1, 16'h5555);
    nop("B4", 16'h0042, 16'h0042);
    nop("B5", 16'h0000, 16'h0042);
    nop("B6", 16'h0505, 16'h0505);

    // producer r6, two independents, then reader of r6 with WB result BEEF
    cyc("C1", 1, 1, 1, 2, 1, 1, 6, 0, 0, 16'h0, 0, 0, 0, 16'h0505);
    cyc("C2", 1, 1, 1, 2, 1, 1, 7, 0, 0, 16'h0, 0, 0, 0, 16'h0505);
    cyc("C3", 1, 1, 1, 2, 1, 1, 5, 0, 0, 16'h0, 0, 0, 0, 16'h0505);
    cyc("C4", 1, 6, 1, 6, 1, 1, 4, 0, 0, 16'hBEEF, 0, 3, 3, 16'hBEEF);
    nop("C5", 16'h0001, 16'h0001);
    nop("C6", 16'h0002, 16'h0002);
    nop("C7", 16'h0003, 16'h0003);

    // EX, MEM and WB all write r1; decode reads r1 on both operands
    cyc("D1", 1, 2, 1, 3, 1, 1, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0003);
    cyc("D2", 1, 2, 1, 3, 1, 1, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0003);
    cyc("D3", 1, 2, 1, 3, 1, 1, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0003);
    cyc("D4", 1, 1, 1, 1, 1, 0, 0, 0, 0, 16'h0111, 0, 2, 2, 16'h0111);
    nop("D5", 16'h0A01, 16'h0A01);
    nop("D6", 16'h0A02, 16'h0A02);
    nop("D7", 16'h0A03, 16'h0A02);

    // flush coincident with a load-use match
    cyc("E1", 1, 1, 1, 0, 0, 1, 3, 1, 0, 16'h0, 0, 0, 0, 16'h0A02);
    cyc("E2", 1, 3, 1, 0, 0, 1, 4, 0, 1, 16'h0, 0, 0, 0, 16'h0A02);
    nop("E3", 16'h0000, 16'h0A02);
    cyc("E4", 1, 4, 1, 3, 1, 0, 0, 0, 0, 16'h0C0C, 0, 0, 3, 16'h0C0C);
    nop("E5", 16'h0000, 16'h0C0C);
    nop("E6", 16'h0000, 16'h0C0C);
    nop("E7", 16'h0000, 16'h0C0C);

    // ADDI with immediate operand whose rt field matches EX dest
    cyc("F1", 1, 1, 1, 2, 1, 1, 5, 0, 0, 16'h0, 0, 0, 0, 16'h0C0C);
    cyc("F2", 1, 1, 1, 5, 0, 1, 6, 0, 0, 16'h0, 0, 0, 0, 16'h0C0C);
    cyc("F3", 1, 2, 1, 0, 0, 1, 7, 1, 0, 16'h0, 0, 0, 0, 16'h0C0C);

    // reset asserted in the middle of a load-use stall
    drive(1, 7, 1, 0, 0, 1, 4, 0, 0, 16'h0);
    #1;
    check("G.stall_pre", {15'd0, stall}, 16'd1);
    #1;
    rst = 1'b1;
    #1;
    check("G.stall_rst", {15'd0, stall}, 16'd0);
    check("G.alu1_rst", {14'd0, frwrd_alu1}, 16'd0);
    check("G.alu2_rst", {14'd0, frwrd_alu2}, 16'd0);
    check("G.wdprev_rst", writedata_prev, 16'h0000);
    $display("[TB] G reset mid-stall stall=%0d wdprev=%h", stall, writedata_prev);
    repeat (2) @(posedge clk);
    #1;
    check("G.stall_hold", {15'd0, stall}, 16'd0);
    rst = 1'b0;
    #1;
    check("G.stall_rel", {15'd0, stall}, 16'd0);
    @(posedge clk);
    #1;
    cyc("G5", 1, 7, 1, 0, 0, 1, 4, 0, 0, 16'h0, 0, 0, 0, 16'h0000);

    check("sb.empty", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
